// File: rtl/full_handshake_rx_fifo.sv
// full_handshake_rx_fifo
// RX-domain end of a four-phase req/ack CDC link (req=1, ack=1, req=0, ack=0).
// The incoming req is synchronised through two flops. Each rising req is
// captured exactly once into a first-word-fall-through FIFO, and the FIFO
// drains to a local valid/ready consumer. When the FIFO is full, ack is
// withheld, so the TX side stalls and no word is dropped.
//
// Optional feature: define HS_RX_LEVEL_EN to add the registered occupancy
// output count_o.
//
// Ports
//   clk          in   1      RX-domain clock
//   rst          in   1      asynchronous active-high reset
//   req_i        in   1      TX request, asynchronous to clk
//   req_data_i   in   DW     TX data, stable while req_i is high until ack
//   ack_o        out  1      registered acknowledge to TX
//   out_valid_o  out  1      FIFO head valid
//   out_data_o   out  DW     FIFO head word (0 when empty)
//   out_ready_i  in   1      consumer pops head when out_valid_o & out_ready_i
//   count_o      out  AW+1   occupancy 0..DEPTH (HS_RX_LEVEL_EN only)
module full_handshake_rx_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    input  logic [DW-1:0] req_data_i,
    output logic          ack_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
`ifdef HS_RX_LEVEL_EN
    output logic [AW:0]   count_o,
`endif
    input  logic          out_ready_i
);

    // One-hot state encoding. The other two codes are illegal and recover to idle.
    localparam logic [1:0] S_IDLE = 2'b01;
    localparam logic [1:0] S_ACK  = 2'b10;

    logic          r_req_d;
    logic          r_req_s;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_ack;
    logic          w_ack_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [DW-1:0] r_mem [DEPTH];

    // Two-flop synchroniser on req. The data bus is not synchronised, because
    // it is held stable by the protocol whenever r_req_s is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_d <= 1'b0;
            r_req_s <= 1'b0;
        end else begin
            r_req_d <= req_i;
            r_req_s <= r_req_d;
        end
    end

    // Pointers carry an extra wrap bit, so full and empty can be told apart.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic. Full is judged on the pre-pop pointers, so a push that
    // is blocked in the same cycle as a pop is retried on the next cycle.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = (r_req_s && !w_full) ? S_ACK : S_IDLE;
            S_ACK:   w_state_nxt = r_req_s ? S_ACK : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic. The only write happens on the idle->ack transition, which
    // gives exactly one entry per req rise.
    always_comb begin
        w_push    = 1'b0;
        w_ack_nxt = 1'b0;
        if (r_state == S_IDLE && r_req_s && !w_full) w_push = 1'b1;
        if (w_state_nxt == S_ACK) w_ack_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ack <= 1'b0;
        else     r_ack <= w_ack_nxt;
    end

    assign ack_o = r_ack;

    assign w_pop = !w_empty && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= req_data_i;
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    assign out_valid_o = !w_empty;
    assign out_data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

`ifdef HS_RX_LEVEL_EN
    logic [AW:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count_o = r_count;
`endif

endmodule

// File: tb/tb_full_handshake_rx_fifo.sv
module tb_full_handshake_rx_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i;
    logic [DW-1:0] req_data_i;
    logic          ack_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i;
    logic [AW:0]   count_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of words plus the handshake rules.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] rcv[$];
    bit            m_ack, m_req_d, m_req_s;
    bit            chk_model = 1'b1;

    full_handshake_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .ack_o      (ack_o),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
`ifdef HS_RX_LEVEL_EN
        .count_o    (count_o),
`endif
        .out_ready_i(out_ready_i)
    );

`ifndef HS_RX_LEVEL_EN
    assign count_o = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_lvl(input string name, input int exp);
`ifdef HS_RX_LEVEL_EN
        chk(name, 32'(count_o), 32'(exp));
`endif
    endtask

    // Advance one clock. The model is updated from the inputs present before
    // the edge, and the DUT is sampled 1 time unit after the edge.
    task automatic step();
        bit full, push, pop;
        full = (mq.size() == DEPTH);
        push = !m_ack && m_req_s && !full;
        pop  = (mq.size() > 0) && out_ready_i;
        if (out_valid_o && out_ready_i) rcv.push_back(out_data_o);
        if (pop)  mq.delete(0);
        if (push) mq.push_back(req_data_i);
        if (push) m_ack = 1'b1;
        else if (m_ack && !m_req_s) m_ack = 1'b0;
        m_req_s = m_req_d;
        m_req_d = req_i;
        @(posedge clk);
        #1;
        if (chk_model) begin
            chk("m_ack",   32'(ack_o),       32'(m_ack));
            chk("m_valid", 32'(out_valid_o), 32'(mq.size() > 0));
            chk("m_data",  out_data_o,       (mq.size() > 0) ? mq[0] : 32'h0);
            chk_lvl("m_count", mq.size());
        end
    endtask

    task automatic wait_ack(input bit lvl);
        for (int i = 0; i < 20 && ack_o != lvl; i++) step();
        chk("ack_wait", 32'(ack_o), 32'(lvl));
    endtask

    task automatic handshake(input logic [DW-1:0] d);
        req_data_i = d;
        req_i      = 1'b1;
        wait_ack(1'b1);
        req_i = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic drain_expect(input logic [DW-1:0] d);
        chk("drain_valid", 32'(out_valid_o), 32'd1);
        chk("drain_data",  out_data_o, d);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          rdy;
        logic          e_ack;
        logic          e_valid;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vt[8];

    initial begin
        // Single transfer: req is sampled at the first edge, so ack and the
        // head word appear two edges later. The fall of req at the fifth edge
        // clears ack two edges later.
        vt[0] = '{1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0};
        vt[1] = '{1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0};
        vt[2] = '{1, 32'hDEAD_BEEF, 0, 1, 1, 32'hDEAD_BEEF};
        vt[3] = '{1, 32'hDEAD_BEEF, 0, 1, 1, 32'hDEAD_BEEF};
        vt[4] = '{0, 32'hDEAD_BEEF, 0, 1, 1, 32'hDEAD_BEEF};
        vt[5] = '{0, 32'hDEAD_BEEF, 0, 1, 1, 32'hDEAD_BEEF};
        vt[6] = '{0, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF};
        vt[7] = '{0, 32'hDEAD_BEEF, 1, 0, 0, 32'h0};

        rst = 1'b1; req_i = 1'b0; req_data_i = '0; out_ready_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ack",   32'(ack_o),       32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data",  out_data_o,       32'd0);
        chk_lvl("rst_count", 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req_i = vt[i].req; req_data_i = vt[i].data; out_ready_i = vt[i].rdy;
            step();
            chk($sformatf("vec%0d_ack", i),   32'(ack_o),       32'(vt[i].e_ack));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_data", i),  out_data_o,       vt[i].e_data);
        end
        out_ready_i = 1'b0;

        // Fill without drain, then a blocked fifth request.
        for (int d = 1; d <= 4; d++) handshake(32'(d));
        chk_lvl("fill_count", 4);
        req_data_i = 32'd5; req_i = 1'b1;
        repeat (6) step();
        chk("full_noack", 32'(ack_o), 32'd0);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        for (int i = 0; i < 2 && !ack_o; i++) step();
        chk("full_ack_after_pop", 32'(ack_o), 32'd1);
        req_i = 1'b0;
        wait_ack(1'b0);
        for (int d = 2; d <= 5; d++) drain_expect(32'(d));
        chk("fill_empty", 32'(out_valid_o), 32'd0);

        // Wrap-around with a consumer that is always ready.
        rcv.delete();
        out_ready_i = 1'b1;
        for (int d = 100; d <= 109; d++) begin
            req_data_i = 32'(d); req_i = 1'b1;
            for (int i = 0; i < 20 && !ack_o; i++) begin
                step();
`ifdef HS_RX_LEVEL_EN
                chk("wrap_lvl", 32'(count_o <= 1), 32'd1);
`endif
            end
            req_i = 1'b0;
            wait_ack(1'b0);
        end
        repeat (2) step();
        out_ready_i = 1'b0;
        chk("wrap_n", 32'(rcv.size()), 32'd10);
        for (int i = 0; i < 10 && i < rcv.size(); i++)
            chk($sformatf("wrap%0d", i), rcv[i], 32'(100 + i));

        // A request held high for 20 cycles writes exactly one word.
        req_data_i = 32'h55; req_i = 1'b1;
        repeat (20) step();
        chk("held_ack", 32'(ack_o), 32'd1);
        chk_lvl("held_count", 1);
        req_i = 1'b0;
        repeat (3) step();
        chk("held_ack_low", 32'(ack_o), 32'd0);
        drain_expect(32'h55);
        chk("held_single", 32'(out_valid_o), 32'd0);

        // Reset while in the ack state with two words queued.
        handshake(32'hAA);
        req_data_i = 32'hBB; req_i = 1'b1;
        wait_ack(1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_ack",   32'(ack_o),       32'd0);
        chk("mrst_valid", 32'(out_valid_o), 32'd0);
        chk_lvl("mrst_count", 0);
        mq.delete(); m_ack = 0; m_req_d = 0; m_req_s = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ack(1'b1);
        chk("mrst_recap", out_data_o, 32'hBB);
        req_i = 1'b0;
        wait_ack(1'b0);
        drain_expect(32'hBB);
        chk("mrst_single", 32'(out_valid_o), 32'd0);

        // Push and pop in the same cycle with two words queued.
        handshake(32'hC1);
        handshake(32'hC2);
        req_data_i = 32'hC3; req_i = 1'b1;
        step(); step();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk_lvl("pp_count", 2);
        chk("pp_head", out_data_o, 32'hC2);
        chk("pp_ack",  32'(ack_o), 32'd1);
        req_i = 1'b0;
        wait_ack(1'b0);
        drain_expect(32'hC2);
        drain_expect(32'hC3);

        // Random traffic that follows the protocol, checked against the model.
        for (int c = 0; c < 400; c++) begin
            if (req_i && ack_o && $urandom_range(0, 2) == 0) req_i = 1'b0;
            else if (!req_i && !ack_o && $urandom_range(0, 1) == 0) begin
                req_data_i = $urandom;
                req_i      = 1'b1;
            end
            out_ready_i = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
